// File: rtl/conv_pkg.sv
// conv_pkg: sizing helpers, FSM state type and result saturation shared by conv_kernel_engine.
package conv_pkg;

  // Widest intermediate handled by sat_to_dw; AccWidth must stay below this.
  localparam int unsigned MaxWidth = 128;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_RUN   = 1'b1
  } conv_state_e;

  function automatic int unsigned ntaps(input int unsigned ksize);
    return ksize * ksize;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ksize);
    return 2 * dw + $clog2(ksize * ksize);
  endfunction

  // Clamp a sign-extended sum into the signed range of a dw-bit result.
  function automatic logic signed [MaxWidth-1:0] sat_to_dw(input logic signed [MaxWidth-1:0] v,
                                                           input int unsigned dw);
    logic signed [MaxWidth-1:0] lo;
    logic signed [MaxWidth-1:0] hi;
    lo = '1;
    lo = lo << (dw - 1);
    hi = ~lo;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: registered signed reduction of NInputs packed operands into one OutWidth sum.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int unsigned InWidth  = 64,
  parameter int unsigned NInputs  = 9,
  parameter int unsigned OutWidth = 68
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NInputs*InWidth-1:0]  in_data,
  input  logic                        in_valid,
  output logic signed [OutWidth-1:0]  sum_out,
  output logic                        sum_valid
);

  logic signed [OutWidth-1:0] sum_next;

  always_comb begin
    sum_next = '0;
    for (int unsigned i = 0; i < NInputs; i++)
      sum_next = sum_next + OutWidth'($signed(in_data[i*InWidth +: InWidth]));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) sum_out <= sum_next;
    end
  end

endmodule

// File: rtl/conv_kernel_engine.sv
// conv_kernel_engine: KSize x KSize signed MAC, double-buffered weights, 3-stage pipeline.
// Define CONV_RELU_EN to fuse a ReLU into the saturation stage.
module conv_kernel_engine
  import conv_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned KSize     = 3,
  parameter int unsigned AccWidth  = acc_width(DataWidth, KSize)
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic [DataWidth-1:0]                   weight_in,
  input  logic                                   weight_valid,
  output logic                                   weights_loaded,
  input  logic [ntaps(KSize)*DataWidth-1:0]      window_in,
  input  logic                                   window_valid,
  output logic [DataWidth-1:0]                   result_out,
  output logic                                   result_valid,
  output logic                                   window_drop
);

  localparam int unsigned NTaps = ntaps(KSize);
  localparam int unsigned IdxW  = $clog2(NTaps);
  localparam int unsigned ProdW = 2 * DataWidth;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NTaps - 1);

  conv_state_e          state;
  logic [DataWidth-1:0] shadow [NTaps];
  logic [DataWidth-1:0] active [NTaps];
  logic [IdxW-1:0]      wr_idx;
  logic                 commit;
  logic                 accept;
  logic [NTaps*ProdW-1:0] prod_next;
  logic [NTaps*ProdW-1:0] s1_prod;
  logic                 s1_valid;
  logic signed [AccWidth-1:0] s2_sum;
  logic                 s2_valid;
  logic [DataWidth-1:0] s3_val;

  assign commit = weight_valid && (wr_idx == LastIdx);
  assign accept = window_valid && (state == S_RUN);

  // The final weight bypasses shadow so active holds the full new kernel right after the commit edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= S_EMPTY;
      wr_idx         <= '0;
      weights_loaded <= 1'b0;
      window_drop    <= 1'b0;
      for (int unsigned k = 0; k < NTaps; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      weights_loaded <= commit;
      if (weight_valid) begin
        shadow[wr_idx] <= weight_in;
        wr_idx         <= commit ? '0 : wr_idx + 1'b1;
      end
      if (commit) begin
        state <= S_RUN;
        for (int unsigned k = 0; k < NTaps - 1; k++) active[k] <= shadow[k];
        active[NTaps-1] <= weight_in;
      end
      if (window_valid && (state == S_EMPTY)) window_drop <= 1'b1;
    end
  end

  // Tap k pairs with lane NTaps-1-k, so tap 0 meets the MS lane of the window.
  always_comb begin
    prod_next = '0;
    for (int unsigned k = 0; k < NTaps; k++)
      prod_next[k*ProdW +: ProdW] =
        ProdW'($signed(active[k])) * ProdW'($signed(window_in[(NTaps-1-k)*DataWidth +: DataWidth]));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_prod  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_prod <= prod_next;
    end
  end

  conv_adder_tree #(
    .InWidth  (ProdW),
    .NInputs  (NTaps),
    .OutWidth (AccWidth)
  ) u_tree (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (s1_prod),
    .in_valid  (s1_valid),
    .sum_out   (s2_sum),
    .sum_valid (s2_valid)
  );

  always_comb begin
    s3_val = DataWidth'(sat_to_dw(MaxWidth'(s2_sum), DataWidth));
`ifdef CONV_RELU_EN
    if (s2_sum[AccWidth-1]) s3_val = '0;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= s2_valid;
      if (s2_valid) result_out <= s3_val;
    end
  end

endmodule

// File: tb/tb_conv_kernel_engine.sv
// Self-checking bench for conv_kernel_engine: 32-bit and 8-bit instances, scoreboard on results.
`timescale 1ns/1ps
module tb_conv_kernel_engine;

  typedef int kern_t [9];
  typedef struct {
    logic signed [31:0] val;
    int                 due;
  } exp_t;
  typedef struct {
    kern_t w;
    kern_t x;
    int    exp;
  } vec_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [31:0]  weight_in;
  logic         weight_valid;
  logic         weights_loaded;
  logic [287:0] window_in;
  logic         window_valid;
  logic [31:0]  result_out;
  logic         result_valid;
  logic         window_drop;

  logic [7:0]   w8_in;
  logic         w8_valid;
  logic         w8_loaded;
  logic [71:0]  x8_in;
  logic         x8_valid;
  logic [7:0]   r8_out;
  logic         r8_valid;
  logic         d8_drop;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   pulses = 0;
  exp_t q32[$];
  exp_t q8[$];

  kern_t K1   = '{6, 2, 1, 1, 3, 0, 0, 4, 2};
  kern_t W1   = '{2, 10, 6, 8, 3, 5, 7, 0, 1};
  kern_t K2   = '{-20, -8, 6, 0, -1, -4, 3, 2, 1};
  kern_t SEQ  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  kern_t REV  = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  kern_t ONES = '{default: 1};
  kern_t BIG  = '{default: 1073741824};
  kern_t NEG  = '{default: -2147483647 - 1};
  kern_t MAXP = '{default: 2147483647};
  vec_t  vecs [7];

  conv_kernel_engine #(.DataWidth(32), .KSize(3)) dut32 (
    .Clk(Clk), .Rst(Rst), .weight_in(weight_in), .weight_valid(weight_valid),
    .weights_loaded(weights_loaded), .window_in(window_in), .window_valid(window_valid),
    .result_out(result_out), .result_valid(result_valid), .window_drop(window_drop)
  );

  conv_kernel_engine #(.DataWidth(8), .KSize(3)) dut8 (
    .Clk(Clk), .Rst(Rst), .weight_in(w8_in), .weight_valid(w8_valid),
    .weights_loaded(w8_loaded), .window_in(x8_in), .window_valid(x8_valid),
    .result_out(r8_out), .result_valid(r8_valid), .window_drop(d8_drop)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) if (weights_loaded) pulses++;

  always @(negedge Clk) begin : mon32
    exp_t e;
    while (q32.size() > 0 && q32[0].due < cyc) begin
      e = q32.pop_front();
      checks++;
      $display("FAIL res32_missing: got nothing, expected %0d at cycle %0d", e.val, e.due);
    end
    if (result_valid) begin
      checks++;
      if (q32.size() == 0)
        $display("FAIL res32_unexpected: got %0d at cycle %0d, expected no result", $signed(result_out), cyc);
      else begin
        e = q32.pop_front();
        if ($signed(result_out) == e.val && cyc == e.due) passed++;
        else $display("FAIL res32: got %0d at cycle %0d, expected %0d at cycle %0d",
                      $signed(result_out), cyc, e.val, e.due);
      end
    end
  end

  always @(negedge Clk) begin : mon8
    exp_t e;
    while (q8.size() > 0 && q8[0].due < cyc) begin
      e = q8.pop_front();
      checks++;
      $display("FAIL res8_missing: got nothing, expected %0d at cycle %0d", e.val, e.due);
    end
    if (r8_valid) begin
      checks++;
      if (q8.size() == 0)
        $display("FAIL res8_unexpected: got %0d at cycle %0d, expected no result", $signed(r8_out), cyc);
      else begin
        e = q8.pop_front();
        if (int'($signed(r8_out)) == e.val && cyc == e.due) passed++;
        else $display("FAIL res8: got %0d at cycle %0d, expected %0d at cycle %0d",
                      $signed(r8_out), cyc, e.val, e.due);
      end
    end
  end

  function automatic logic [287:0] pack32(input kern_t v);
    logic [287:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[(8-i)*32 +: 32] = v[i];
    return r;
  endfunction

  function automatic int relu(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push32(input int v);
    q32.push_back('{val: relu(v), due: cyc + 3});
  endtask

  // mode 0: no windows; 1: all-ones window every weight cycle; 2: all-ones window with last weight only
  task automatic load_kernel(input kern_t w, input int mode, input int old_exp, input int gap_after);
    int p0;
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      if (gap_after != 0 && i == gap_after) begin
        weight_valid = 1'b0;
        window_valid = 1'b0;
        repeat (3) tick();
        check("no_early_commit", pulses - p0, 0);
      end
      weight_in    = w[i];
      weight_valid = 1'b1;
      window_in    = pack32(ONES);
      window_valid = (mode == 1) || (mode == 2 && i == 8);
      if (window_valid) push32(old_exp);
      tick();
    end
    weight_valid = 1'b0;
    window_valid = 1'b0;
    check("weights_loaded_pulse", weights_loaded, 1);
    tick();
    check("weights_loaded_low", weights_loaded, 0);
    check("single_commit", pulses - p0, 1);
  endtask

  task automatic send_window(input kern_t x, input int n, input int exp);
    window_in = pack32(x);
    for (int i = 0; i < n; i++) begin
      window_valid = 1'b1;
      push32(exp);
      tick();
    end
    window_valid = 1'b0;
  endtask

  task automatic run8(input int wv, input int xv, input int exp);
    for (int i = 0; i < 9; i++) begin
      w8_in    = 8'(wv);
      w8_valid = 1'b1;
      tick();
    end
    w8_valid = 1'b0;
    check("w8_loaded", w8_loaded, 1);
    x8_in    = {9{8'(xv)}};
    x8_valid = 1'b1;
    q8.push_back('{val: relu(exp), due: cyc + 3});
    tick();
    x8_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].w = K1;   vecs[0].x = W1;   vecs[0].exp = 57;
    vecs[1].w = K1;   vecs[1].x = ONES; vecs[1].exp = 19;
    vecs[2].w = K2;   vecs[2].x = ONES; vecs[2].exp = -21;
    vecs[3].w = K2;   vecs[3].x = W1;   vecs[3].exp = -85;
    vecs[4].w = BIG;  vecs[4].x = BIG;  vecs[4].exp = 2147483647;
    vecs[5].w = NEG;  vecs[5].x = MAXP; vecs[5].exp = -2147483647 - 1;
    vecs[6].w = SEQ;  vecs[6].x = REV;  vecs[6].exp = 165;

    Rst = 1'b1;
    weight_in = '0; weight_valid = 1'b0; window_in = '0; window_valid = 1'b0;
    w8_in = '0; w8_valid = 1'b0; x8_in = '0; x8_valid = 1'b0;
    repeat (3) tick();
    check("rst_result_out", result_out, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_weights_loaded", weights_loaded, 0);
    check("rst_window_drop", window_drop, 0);
    check("rst8_result_out", r8_out, 0);
    check("rst8_window_drop", d8_drop, 0);
    Rst = 1'b0;
    tick();

    // Window before any kernel: dropped, sticky flag.
    window_in = pack32(W1);
    window_valid = 1'b1;
    tick();
    window_valid = 1'b0;
    repeat (5) tick();
    check("drop_set", window_drop, 1);

    // First kernel, window held for five cycles.
    load_kernel(K1, 0, 0, 0);
    send_window(W1, 5, 57);
    repeat (2) tick();
    check("drop_sticky", window_drop, 1);

    // Reload while streaming: old kernel until commit, new kernel after.
    load_kernel(K2, 1, 19, 0);
    send_window(ONES, 3, -21);

    // Gapped load; last weight coincides with a window that must use the old kernel.
    load_kernel(SEQ, 2, -21, 4);
    send_window(ONES, 1, 45);
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      load_kernel(vecs[i].w, 0, 0, 0);
      send_window(vecs[i].x, 1, vecs[i].exp);
    end
    repeat (6) tick();
    check("drain32", q32.size(), 0);

    // 8-bit saturation at both ends.
    run8(127, 127, 127);
    run8(-128, 127, -128);
    repeat (6) tick();
    check("drain8", q8.size(), 0);

    // Reset with a partial shadow load and two results in flight.
    for (int i = 0; i < 4; i++) begin
      weight_in = K2[i];
      weight_valid = 1'b1;
      tick();
    end
    weight_valid = 1'b0;
    window_in = pack32(W1);
    window_valid = 1'b1;
    tick();
    tick();
    window_valid = 1'b0;
    q32.delete();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("rst_mid_drop_cleared", window_drop, 0);
    check("rst_mid_result_valid", result_valid, 0);
    repeat (5) tick();
    check("rst_mid_no_late_result", result_valid, 0);
    window_in = pack32(W1);
    window_valid = 1'b1;
    tick();
    window_valid = 1'b0;
    repeat (4) tick();
    check("rst_mid_drop_again", window_drop, 1);
    load_kernel(K1, 0, 0, 0);
    send_window(W1, 1, 57);
    repeat (6) tick();
    check("drain_final", q32.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
